// File: rtl/smc_arb_pkg.sv
// Shared types and constants for the SMC access arbiters.
package smc_arb_pkg;

    localparam int unsigned WDOG_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/smc_access_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module smc_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               valid_o_c,
    output logic [IDX_W-1:0]   idx_o_c,
    output logic [NUM_REQ-1:0] onehot_o_c
);

    always_comb begin
        int unsigned j;
        j          = 0;
        valid_o_c  = 1'b0;
        idx_o_c    = '0;
        onehot_o_c = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = 32'(ptr_i) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!valid_o_c && req_i[IDX_W'(j)]) begin
                valid_o_c  = 1'b1;
                idx_o_c    = IDX_W'(j);
                onehot_o_c = NUM_REQ'(1) << j;
            end
        end
    end

endmodule

// File: rtl/smc_access_arbiter.sv
// Arbitrates NUM_REQ requesters onto the SMC core: RR grant, issue, wait for done,
// with burst locking and a per-access watchdog.
module smc_access_arbiter
    import smc_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CS_W    = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    sys_clk,
    input  logic                    sys_reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      req_n_read,
    input  logic [NUM_REQ*CS_W-1:0] req_cs,
    input  logic [NUM_REQ-1:0]      req_lock,
    input  logic                    valid_access,
    input  logic                    smc_done,
    input  logic                    smc_idle,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      ack,
    output logic [NUM_REQ-1:0]      done,
    output logic                    new_access,
    output logic                    n_read,
    output logic [CS_W-1:0]         cs,
    output logic                    timeout_err
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                new_access_q, new_access_d;
    logic                n_read_q, n_read_d;
    logic [CS_W-1:0]     cs_q, cs_d;
    logic                timeout_q, timeout_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                lock_q, lock_d;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [CS_W-1:0]     cs_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cs_unpack
        assign cs_arr[i] = req_cs[i*CS_W +: CS_W];
    end

    smc_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i      (req),
        .ptr_i      (ptr_q),
        .valid_o_c  (pick_valid),
        .idx_o_c    (pick_idx),
        .onehot_o_c (pick_onehot)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            gidx_q       <= '0;
            ack_q        <= '0;
            done_q       <= '0;
            new_access_q <= 1'b0;
            n_read_q     <= 1'b1;
            cs_q         <= '0;
            timeout_q    <= 1'b0;
            ptr_q        <= '0;
            wdog_q       <= '0;
            lock_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            gidx_q       <= gidx_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            new_access_q <= new_access_d;
            n_read_q     <= n_read_d;
            cs_q         <= cs_d;
            timeout_q    <= timeout_d;
            ptr_q        <= ptr_d;
            wdog_q       <= wdog_d;
            lock_q       <= lock_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        gidx_d       = gidx_q;
        ack_d        = '0;
        done_d       = '0;
        new_access_d = new_access_q;
        n_read_d     = n_read_q;
        cs_d         = cs_q;
        timeout_d    = 1'b0;
        ptr_d        = ptr_q;
        wdog_d       = wdog_q;
        lock_d       = lock_q;

        unique case (state_q)
            ST_IDLE: begin
                if (smc_idle && pick_valid) begin
                    state_d      = ST_ISSUE;
                    gnt_d        = pick_onehot;
                    gidx_d       = pick_idx;
                    cs_d         = cs_arr[pick_idx];
                    n_read_d     = req_n_read[pick_idx];
                    new_access_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                // Acceptance beats a same-cycle withdrawal.
                if (valid_access) begin
                    state_d      = ST_WAIT;
                    ack_d        = gnt_q;
                    lock_d       = req_lock[gidx_q];
                    ptr_d        = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
                    wdog_d       = '0;
                    new_access_d = 1'b0;
                end else if (!req[gidx_q]) begin
                    state_d      = ST_IDLE;
                    gnt_d        = '0;
                    new_access_d = 1'b0;
                end
            end
            ST_WAIT: begin
                wdog_d = wdog_q + WDOG_W'(1);
                if (smc_done) begin
                    done_d = gnt_q;
                    // Locked burst re-issues straight away, skipping arbitration.
                    if (lock_q && req[gidx_q]) begin
                        state_d      = ST_ISSUE;
                        new_access_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign gnt         = gnt_q;
    assign ack         = ack_q;
    assign done        = done_q;
    assign new_access  = new_access_q;
    assign n_read      = n_read_q;
    assign cs          = cs_q;
    assign timeout_err = timeout_q;

endmodule
